// File: rtl/tx_arb.sv
// Two-requester round-robin arbiter feeding a 16-bit transmitter (IDLE/XMIT).
// Optional XMIT timeout enabled by defining TX_ARB_TMO_EN (limit = TMO_CYCLES).
module tx_arb #(
  parameter int unsigned TMO_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        cmplt0,
  output logic        cmplt1,
  output logic [15:0] tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        busy,
  output logic        err
);

  typedef enum logic {IDLE, XMIT} state_t;

  state_t state;
  logic   ptr;     // requester that wins a tie on the next grant
  logic   gnt_id;  // requester owning the word currently in flight
  logic   win_id;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    win_id = (req0 & req1) ? ptr : req1;
  end

`ifdef TX_ARB_TMO_EN
  localparam int unsigned CW = $clog2(TMO_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          err_r;

  assign tmo_hit = (tmo_cnt == CW'(TMO_CYCLES - 1));
  assign err     = err_r;
`else
  // Timeout logic absent; the expression folds to a constant 0.
  assign err = 1'b0 & (TMO_CYCLES == 0);
`endif

  // NOTE: every state bit here is a flop updated with <=, so all reads in this
  // block see pre-edge values and the pulse defaults below cannot race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      gnt_id  <= 1'b0;
      trmt    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      cmplt0  <= 1'b0;
      cmplt1  <= 1'b0;
      busy    <= 1'b0;
      tx_data <= 16'h0000;
`ifdef TX_ARB_TMO_EN
      tmo_cnt <= '0;
      err_r   <= 1'b0;
`endif
    end else begin
      trmt   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      cmplt0 <= 1'b0;
      cmplt1 <= 1'b0;
`ifdef TX_ARB_TMO_EN
      err_r  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state   <= XMIT;
            busy    <= 1'b1;
            trmt    <= 1'b1;
            ack0    <= ~win_id;
            ack1    <= win_id;
            tx_data <= win_id ? data1 : data0;
            gnt_id  <= win_id;
            ptr     <= ~win_id;
`ifdef TX_ARB_TMO_EN
            tmo_cnt <= '0;
`endif
          end
        end
        XMIT: begin
          // A tx_done coincident with the start pulse belongs to an older word.
          if (tx_done && !trmt) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cmplt0 <= ~gnt_id;
            cmplt1 <= gnt_id;
          end
`ifdef TX_ARB_TMO_EN
          else if (tmo_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
            err_r <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arb.sv
// Directed self-checking bench for tx_arb; timeout branch built when
// TX_ARB_TMO_EN is defined (TMO_CYCLES = 16).
module tb_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, tx_done = 1'b0;
  logic [15:0] data0 = 16'h0000, data1 = 16'h0000;
  logic        ack0, ack1, cmplt0, cmplt1, trmt, busy, err;
  logic [15:0] tx_data;

  int checks = 0;
  int errors = 0;

  tx_arb #(.TMO_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .cmplt0(cmplt0), .cmplt1(cmplt1),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {trmt, ack1, ack0, cmplt1, cmplt0, busy, err}
  function automatic logic [6:0] outs();
    return {trmt, ack1, ack0, cmplt1, cmplt0, busy, err};
  endfunction

  initial begin
    logic ok;

    // Reset state
    #3;
    check("reset_outs", outs(), 7'b0);
    check("reset_txdata", tx_data, 16'h0000);
    tick();
    rst_n = 1'b1;

    // Single requester 0, tx_done after 20 cycles
    req0 = 1'b1; data0 = 16'hA55A;
    tick();
    check("a_grant_outs", outs(), 7'b1_01_00_1_0);
    check("a_grant_data", tx_data, 16'hA55A);
    req0 = 1'b0; data0 = 16'hFFFF;
    tick();
    check("a_trmt_one_cycle", outs(), 7'b0_00_00_1_0);
    for (int i = 0; i < 18; i++) tick();
    check("a_data_held", tx_data, 16'hA55A);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("a_cmplt0", outs(), 7'b0_00_01_0_0);
    tick();
    check("a_cmplt_one_cycle", outs(), 7'b0);

    // Both requesting from reset: grants 0,1,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h1234; data1 = 16'h5678;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("b_grant%0d_outs", i), outs(),
            (i % 2) ? 7'b1_10_00_1_0 : 7'b1_01_00_1_0);
      check($sformatf("b_grant%0d_data", i), tx_data,
            (i % 2) ? 16'h5678 : 16'h1234);
      tick();
      check($sformatf("b_trmt%0d_drop", i), outs(), 7'b0_00_00_1_0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check($sformatf("b_cmplt%0d", i), outs(),
            (i % 2) ? 7'b0_00_10_0_0 : 7'b0_00_01_0_0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // req1 raised during requester 0's XMIT
    req0 = 1'b1; data0 = 16'h1111;
    tick();
    check("c_grant0", outs(), 7'b1_01_00_1_0);
    req0 = 1'b0;
    tick();
    req1 = 1'b1; data1 = 16'h2222;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack1 !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    check("c_no_ack1_while_busy", ok, 1'b1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("c_cmplt0_no_ack1", outs(), 7'b0_00_01_0_0);
    tick();
    check("c_grant1_two_after", outs(), 7'b1_10_00_1_0);
    check("c_grant1_data", tx_data, 16'h2222);
    req1 = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("c_cmplt1", outs(), 7'b0_00_10_0_0);

    // tx_done in IDLE ignored; withdrawn request never granted
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("d_idle_txdone", outs(), 7'b0);
    req0 = 1'b1; data0 = 16'h3333;
    tick();
    check("d_grant0", outs(), 7'b1_01_00_1_0);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; data0 = 16'h9999;
    tick();
    req0 = 1'b0;
    check("d_no_ack_busy", outs(), 7'b0_00_00_1_0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("d_cmplt0", outs(), 7'b0_00_01_0_0);
    tick();
    check("d_withdrawn", outs(), 7'b0);
    check("d_data_kept", tx_data, 16'h3333);

    // Reset mid-XMIT, pointer returns to requester 0
    req1 = 1'b1; data1 = 16'h4444;
    tick();
    check("e_grant1", outs(), 7'b1_10_00_1_0);
    req1 = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h5555; data1 = 16'h6666;
    #2 rst_n = 1'b0;
    #1;
    check("e_async_reset_outs", outs(), 7'b0);
    check("e_async_reset_data", tx_data, 16'h0000);
    tick();
    check("e_held_reset_outs", outs(), 7'b0);
    rst_n = 1'b1;
    tick();
    check("e_first_grant0", outs(), 7'b1_01_00_1_0);
    check("e_first_grant_data", tx_data, 16'h5555);
    req0 = 1'b0;

`ifdef TX_ARB_TMO_EN
    ok = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (busy !== 1'b1 || err !== 1'b0) ok = 1'b0;
    end
    check("f_busy_before_tmo", ok, 1'b1);
    tick();
    check("f_err_pulse", outs(), 7'b0_00_00_0_1);
    tick();
    check("f_next_grant1", outs(), 7'b1_10_00_1_0);
    check("f_next_grant_data", tx_data, 16'h6666);
`else
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (busy !== 1'b1 || err !== 1'b0 || ack1 !== 1'b0) ok = 1'b0;
    end
    check("f_busy_no_timeout", ok, 1'b1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("f_late_cmplt0", outs(), 7'b0_00_01_0_0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_arb.md
TX_ARB -- requirements
Module: tx_arb

Interface
REQ-001 Parameter TMO_CYCLES, default 4096: XMIT-state cycle limit before timeout; used only when TX_ARB_TMO_EN is defined.
REQ-002 clk  input  1  system clock, all flops rising-edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req0  input  1  requester 0 transmit request, level, held until ack0.
REQ-005 data0  input  16  requester 0 word, valid while req0=1.
REQ-006 req1  input  1  requester 1 transmit request, level, held until ack1.
REQ-007 data1  input  16  requester 1 word, valid while req1=1.
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: word accepted and latched.
REQ-009 cmplt0, cmplt1  output  1 each  one-cycle pulse: that requester's word fully transmitted.
REQ-010 tx_data  output  16  registered word to the 16-bit transmitter.
REQ-011 trmt  output  1  one-cycle start pulse to the transmitter.
REQ-012 tx_done  input  1  transmitter pulse: both bytes sent.
REQ-013 busy  output  1  high in XMIT state.
REQ-014 err  output  1  one-cycle timeout pulse; constant 0 without TX_ARB_TMO_EN.

Function
REQ-015 States: IDLE, XMIT; all outputs are registered.
REQ-016 IDLE with req0|req1 sampled high at edge N: at N+1 trmt=1, the winner's ackX=1, tx_data=winner's data, busy=1, state=XMIT.
REQ-017 Arbitration is round-robin via a 1-bit priority pointer; on simultaneous requests, the pointed requester wins; a lone requester wins regardless of the pointer.
REQ-018 After each grant, the pointer points to the non-granted requester.
REQ-019 trmt and ackX are high exactly one cycle per grant; at most one ack per grant.
REQ-020 tx_data holds its value from the grant until the next grant; data0/data1 changes after ack are ignored.
REQ-021 XMIT with tx_done sampled high at edge M: at M+1 cmpltX=1 for the granted requester, busy=0, state=IDLE.
REQ-022 Minimum spacing: next trmt no earlier than 2 cycles after tx_done (one IDLE sample cycle).
REQ-023 Requests arriving during XMIT stay pending and are arbitrated on return to IDLE.
REQ-024 Request dropped before ack = withdrawn; no ack, no transmit.
REQ-025 tx_done in IDLE is ignored: no cmplt, no state change.
REQ-026 tx_done in the same cycle a grant is issued is not counted for the new word.

Reset
REQ-027 On rst_n low, immediately: state=IDLE, pointer=requester 0, trmt=ack0=ack1=cmplt0=cmplt1=busy=err=0, tx_data=16'h0000, timeout counter=0.
REQ-028 Reset mid-XMIT aborts the word with no cmplt or err; the first grant after release follows REQ-016 with pointer=0.

Configuration
REQ-029 Macro TX_ARB_TMO_EN defined: counter clears on entering XMIT and increments each XMIT cycle; when it reaches TMO_CYCLES without tx_done, next cycle err=1 (one cycle), no cmplt, busy=0, state=IDLE; pointer already advanced per REQ-018.
REQ-030 Macro TX_ARB_TMO_EN defined, tx_done on the same edge as the limit: tx_done wins, cmplt issued, err=0.
REQ-031 Macro TX_ARB_TMO_EN undefined: no counter logic, XMIT waits indefinitely, err tied 0.

Verification
REQ-032 Reset, req0=1, data0=16'hA55A -> one cycle later trmt=1, ack0=1, tx_data=16'hA55A; tx_done after 20 cycles -> cmplt0 next cycle, busy=0.
REQ-033 req0=req1=1 from reset, data0=16'h1234, data1=16'h5678 -> grants order 0,1,0,1; tx_data 16'h1234 then 16'h5678; each trmt exactly one cycle.
REQ-034 req1 raised during XMIT of requester 0 -> no ack1 until XMIT ends; grant to 1 exactly 2 cycles after tx_done.
REQ-035 tx_done pulsed in IDLE, and req0 pulsed one cycle then dropped while busy -> no cmplt, no ack0, no trmt.
REQ-036 rst_n low mid-XMIT, then req0=req1=1 -> all outputs 0 during reset; first grant to requester 0.
REQ-037 With TX_ARB_TMO_EN and TMO_CYCLES=16, no tx_done -> err=1 one cycle after 16 XMIT cycles, no cmplt, next pending requester granted; without macro, busy stays 1 for 1000 cycles.
